// File: rtl/snitch_pkg.sv
// Shared type definitions for the Snitch stream-control blocks.
package snitch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } streamctl_state_e;

endpackage

// File: rtl/snitch_streamctl_gen.sv
// Loop token generator: issues one token per instruction of each iteration,
// gated by SSR operand credits, and closes every loop with a done token.
module snitch_streamctl_gen
  import snitch_pkg::*;
#(
  parameter int unsigned CntWidth    = 32,
  parameter int unsigned BodyWidth   = 5,
  parameter int unsigned CreditWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CntWidth-1:0]  cfg_num_iter_i,
  input  logic [BodyWidth-1:0] cfg_body_len_i,
  input  logic                 avail_valid_i,
  output logic                 avail_ready_o,
  input  logic                 abort_i,
  output logic                 streamctl_valid_o,
  output logic                 streamctl_done_o,
  input  logic                 streamctl_ready_i,
  output logic                 busy_o
);

  localparam logic [CreditWidth-1:0] CreditMax = '1;

  streamctl_state_e       state_q, state_d;
  logic [CreditWidth-1:0] credit_q, credit_d;
  logic [CntWidth-1:0]    iter_q, iter_d;
  logic [BodyWidth-1:0]   inst_q, inst_d;
  logic                   abort_q, abort_d;
  logic [CntWidth-1:0]    num_q, num_d;
  logic [BodyWidth-1:0]   len_q, len_d;

  logic cfg_hs, tok_hs, run_hs, avail_hs;
  logic last_inst, last_iter, cred_dec, abort_eff;

  // Outputs depend on registered state only (plus the credit decrement for
  // avail_ready_o), so ready never feeds back into valid.
  always_comb begin
    cfg_ready_o       = (state_q == StIdle);
    busy_o            = (state_q != StIdle);
    streamctl_valid_o = 1'b0;
    streamctl_done_o  = 1'b0;
    unique case (state_q)
      StRun:   streamctl_valid_o = (credit_q != '0);
      StDone: begin
        streamctl_valid_o = 1'b1;
        streamctl_done_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign cfg_hs        = cfg_valid_i & cfg_ready_o;
  assign tok_hs        = streamctl_valid_o & streamctl_ready_i;
  assign run_hs        = (state_q == StRun) & tok_hs;
  assign last_inst     = (inst_q == len_q - BodyWidth'(1));
  assign last_iter     = (iter_q == num_q - CntWidth'(1));
  assign cred_dec      = run_hs & last_inst;
  assign avail_ready_o = (credit_q != CreditMax) | cred_dec;
  assign avail_hs      = avail_valid_i & avail_ready_o;
  // A same-cycle abort counts too, so abort right after a token stops after
  // at most the token currently on offer.
  assign abort_eff     = abort_q | abort_i;

  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    inst_d   = inst_q;
    abort_d  = abort_q;
    num_d    = num_q;
    len_d    = len_q;
    credit_d = credit_q;

    unique case ({avail_hs, cred_dec})
      2'b10:   credit_d = credit_q + CreditWidth'(1);
      2'b01:   credit_d = credit_q - CreditWidth'(1);
      default: ;
    endcase

    unique case (state_q)
      StIdle: begin
        if (cfg_hs) begin
          num_d   = cfg_num_iter_i;
          len_d   = (cfg_body_len_i == '0) ? BodyWidth'(1) : cfg_body_len_i;
          state_d = (cfg_num_iter_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (abort_i) abort_d = 1'b1;
        if (run_hs) begin
          if (last_inst) begin
            inst_d = '0;
            iter_d = iter_q + CntWidth'(1);
          end else begin
            inst_d = inst_q + BodyWidth'(1);
          end
          if ((last_inst && last_iter) || abort_eff) state_d = StDone;
        end else if (!streamctl_valid_o && abort_eff) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (tok_hs) begin
          state_d  = StIdle;
          credit_d = '0;
          iter_d   = '0;
          inst_d   = '0;
          abort_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      credit_q <= '0;
      iter_q   <= '0;
      inst_q   <= '0;
      abort_q  <= 1'b0;
      num_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      iter_q   <= iter_d;
      inst_q   <= inst_d;
      abort_q  <= abort_d;
      num_q    <= num_d;
      len_q    <= len_d;
    end
  end

endmodule

// File: tb/tb_snitch_streamctl_gen.sv
// Directed bench for snitch_streamctl_gen: per-cycle vector table plus
// hand-written abort, saturation, backpressure and reset sequences.
module tb_snitch_streamctl_gen;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [31:0] cfg_num_iter_i;
  logic [4:0]  cfg_body_len_i;
  logic        avail_valid_i;
  logic        avail_ready_o;
  logic        abort_i;
  logic        streamctl_valid_o;
  logic        streamctl_done_o;
  logic        streamctl_ready_i;
  logic        busy_o;

  always #5 clk = ~clk;

  snitch_streamctl_gen #(.CntWidth(32), .BodyWidth(5), .CreditWidth(4)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .cfg_valid_i       (cfg_valid_i),
    .cfg_ready_o       (cfg_ready_o),
    .cfg_num_iter_i    (cfg_num_iter_i),
    .cfg_body_len_i    (cfg_body_len_i),
    .avail_valid_i     (avail_valid_i),
    .avail_ready_o     (avail_ready_o),
    .abort_i           (abort_i),
    .streamctl_valid_o (streamctl_valid_o),
    .streamctl_done_o  (streamctl_done_o),
    .streamctl_ready_i (streamctl_ready_i),
    .busy_o            (busy_o)
  );

  // Expected output vectors: {cfg_ready, avail_ready, valid, done, busy}
  localparam logic [4:0] IDLE = 5'b11000;
  localparam logic [4:0] RUNV = 5'b01101;
  localparam logic [4:0] RUNN = 5'b01001;
  localparam logic [4:0] DONE = 5'b01111;

  typedef struct {
    logic        cv;
    logic [31:0] n;
    logic [4:0]  l;
    logic        av;
    logic        ab;
    logic        rdy;
    logic [4:0]  exp;
  } vec_t;

  vec_t tbl[$];
  int   errs   = 0;
  int   checks = 0;

  function automatic logic [4:0] outs();
    return {cfg_ready_o, avail_ready_o, streamctl_valid_o, streamctl_done_o, busy_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic cv, input logic [31:0] n, input logic [4:0] l,
                     input logic av, input logic ab, input logic rdy, input logic [4:0] exp);
    vec_t v;
    v.cv = cv; v.n = n; v.l = l; v.av = av; v.ab = ab; v.rdy = rdy; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic cv, input logic [31:0] n, input logic [4:0] l,
                       input logic av, input logic ab, input logic rdy);
    cfg_valid_i = cv; cfg_num_iter_i = n; cfg_body_len_i = l;
    avail_valid_i = av; abort_i = ab; streamctl_ready_i = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int k);
    for (int i = 0; i < k; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      tick();
    end
  endtask

  initial begin
    int tokens, seen_done, aborted, pend, pdone, vcnt, hs;

    drive(0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), IDLE);
    rst_ni = 1'b1;

    // Basic loop N=2 L=3 with 2 credits preloaded
    add(0, 0, 0, 1, 0, 1, IDLE);
    add(0, 0, 0, 1, 0, 1, IDLE);
    add(1, 2, 3, 0, 0, 1, IDLE);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 1, RUNV);
    add(0, 0, 0, 0, 0, 1, DONE);
    add(0, 0, 0, 0, 0, 1, IDLE);
    // Credit starvation N=2 L=1
    add(1, 2, 1, 0, 0, 1, IDLE);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 1, RUNN);
    add(0, 0, 0, 1, 0, 1, RUNN);
    add(0, 0, 0, 0, 0, 1, RUNV);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 1, RUNN);
    add(0, 0, 0, 1, 0, 1, RUNN);
    add(0, 0, 0, 0, 0, 1, RUNV);
    add(0, 0, 0, 0, 0, 1, DONE);
    add(0, 0, 0, 0, 1, 1, IDLE);
    // Zero-iteration loop, done held under backpressure
    add(1, 0, 3, 0, 0, 0, IDLE);
    add(0, 0, 0, 0, 0, 0, DONE);
    add(0, 0, 0, 0, 0, 1, DONE);
    add(0, 0, 0, 0, 0, 1, IDLE);
    // L=0 behaves as L=1
    add(0, 0, 0, 1, 0, 1, IDLE);
    add(1, 1, 0, 0, 0, 1, IDLE);
    add(0, 0, 0, 0, 0, 1, RUNV);
    add(0, 0, 0, 0, 0, 1, DONE);
    add(0, 0, 0, 0, 0, 1, IDLE);
    // Abort while starved leaves RUN without a token
    add(1, 2, 1, 0, 0, 1, IDLE);
    add(0, 0, 0, 0, 1, 1, RUNN);
    add(0, 0, 0, 0, 0, 1, DONE);
    add(0, 0, 0, 0, 0, 1, IDLE);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].cv, tbl[i].n, tbl[i].l, tbl[i].av, tbl[i].ab, tbl[i].rdy);
      #4;
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      tick();
    end

    // Abort one cycle after the 3rd token: only the token on offer completes
    preload(8);
    drive(1, 100, 2, 0, 0, 1);
    tick();
    tokens = 0; seen_done = 0; aborted = 0;
    for (int c = 0; c < 60 && seen_done == 0; c++) begin
      drive(0, 0, 0, 0, (tokens == 3 && aborted == 0), 1);
      if (tokens == 3) aborted = 1;
      #4;
      if (streamctl_valid_o && streamctl_ready_i) begin
        if (streamctl_done_o) seen_done = 1;
        else tokens++;
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("abort_tokens", tokens, 4);
    chk("abort_done_seen", seen_done, 1);
    #4;
    chk("abort_idle", outs(), IDLE);
    tick();

    // Credit saturation at 15
    for (int k = 0; k < 15; k++) begin
      drive(0, 0, 0, 1, 0, 0);
      #4;
      chk($sformatf("sat_ready%0d", k), avail_ready_o, 1);
      tick();
    end
    drive(0, 0, 0, 1, 0, 0);
    #4;
    chk("sat_full", avail_ready_o, 0);
    tick();
    drive(1, 1, 1, 0, 0, 0);
    #4;
    chk("sat_full_cfg", outs(), 5'b10000);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    #4;
    chk("sat_dec_ready", outs(), RUNV);
    tick();
    #4;
    chk("sat_done", outs(), DONE);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #4;
    chk("sat_cleared", outs(), IDLE);
    tick();

    // Random backpressure: offered token must hold until taken
    preload(6);
    drive(1, 3, 2, 0, 0, 0);
    tick();
    tokens = 0; seen_done = 0; pend = 0; pdone = 0;
    for (int c = 0; c < 300 && seen_done == 0; c++) begin
      drive(0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
      #4;
      if (pend != 0)
        chk("bp_hold", {streamctl_valid_o, streamctl_done_o}, {1'b1, 1'(pdone)});
      pend  = streamctl_valid_o & ~streamctl_ready_i;
      pdone = streamctl_done_o;
      if (streamctl_valid_o && streamctl_ready_i) begin
        if (streamctl_done_o) seen_done = 1;
        else tokens++;
      end
      tick();
    end
    chk("bp_tokens", tokens, 6);
    chk("bp_done_seen", seen_done, 1);

    // Reset in the middle of RUN
    preload(4);
    drive(1, 5, 1, 0, 0, 1);
    tick();
    hs = 0;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      drive(0, 0, 0, 0, 0, 1);
      #4;
      if (streamctl_valid_o && streamctl_ready_i) hs++;
      tick();
    end
    chk("rst_pre_tokens", hs, 2);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_run", outs(), IDLE);
    #3;
    rst_ni = 1'b1;
    tick();
    vcnt = 0;
    for (int c = 0; c < 10; c++) begin
      #4;
      if (streamctl_valid_o) vcnt++;
      tick();
    end
    chk("rst_no_token", vcnt, 0);
    chk("rst_idle", outs(), IDLE);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
